// File: rtl/bsg_dmc_ui_responder.sv
// bsg_dmc_ui_responder
//   Behavioural stand-in for a MIG-style DRAM controller user interface.
//   Commands and write beats are queued independently and executed strictly
//   in command order against a small internal word memory. Read bursts come
//   back a fixed number of cycles after the read leaves the command queue.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   app_addr_i/cmd_i/en_i   command address (words), opcode, valid
//   app_rdy_o               command ready
//   app_wdf_*_i             write beat valid/data/mask/end (mask 1 = keep byte)
//   app_wdf_rdy_o           write data ready
//   app_rd_data_*_o         read beat valid/data/end (no backpressure)
//   stall_i                 forces both ready outputs low
//   error_o                 sticky write-burst framing error
//   busy_o                  burst in progress or any queue non-empty
//
// Handshake: a command (resp. write beat) transfers on a rising edge where
// both app_en_i (app_wdf_wren_i) and app_rdy_o (app_wdf_rdy_o) are high.
// Ready depends only on reset_i, stall_i and the registered queue counts,
// never on the valid inputs. Read beats are pushed with no ready.
//
// The FSM state is held in state_q (type state_e) for checkers to bind to.

module bsg_dmc_ui_responder #(
  parameter int ui_addr_width_p  = 28,
  parameter int ui_data_width_p  = 32,
  parameter int ui_burst_len_p   = 4,
  parameter int mem_els_lg_p     = 6,
  parameter int cmd_fifo_depth_p = 4,
  parameter int wdf_fifo_depth_p = 8,
  parameter int read_latency_p   = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [ui_addr_width_p-1:0]   app_addr_i,
  input  logic [2:0]                   app_cmd_i,
  input  logic                         app_en_i,
  output logic                         app_rdy_o,
  input  logic                         app_wdf_wren_i,
  input  logic [ui_data_width_p-1:0]   app_wdf_data_i,
  input  logic [ui_data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                         app_wdf_end_i,
  output logic                         app_wdf_rdy_o,
  output logic                         app_rd_data_valid_o,
  output logic [ui_data_width_p-1:0]   app_rd_data_o,
  output logic                         app_rd_data_end_o,
  input  logic                         stall_i,
  output logic                         error_o,
  output logic                         busy_o
);

  localparam int mask_w_lp   = ui_data_width_p / 8;
  localparam int mem_els_lp  = 1 << mem_els_lg_p;
  localparam int burst_lg_lp = $clog2(ui_burst_len_p);
  localparam int beat_w_lp   = (burst_lg_lp == 0) ? 1 : burst_lg_lp;
  localparam int cmd_ptr_w_lp = (cmd_fifo_depth_p > 1) ? $clog2(cmd_fifo_depth_p) : 1;
  localparam int wdf_ptr_w_lp = (wdf_fifo_depth_p > 1) ? $clog2(wdf_fifo_depth_p) : 1;
  localparam int cmd_cnt_w_lp = $clog2(cmd_fifo_depth_p + 1);
  localparam int wdf_cnt_w_lp = $clog2(wdf_fifo_depth_p + 1);
  localparam int lat_w_lp     = (read_latency_p > 1) ? $clog2(read_latency_p) : 1;
  localparam int lat_last_lp  = (read_latency_p == 0) ? 0 : read_latency_p - 1;
  localparam int cmd_entry_w_lp = 3 + mem_els_lg_p;
  localparam int wdf_entry_w_lp = ui_data_width_p + mask_w_lp + 1;

  localparam logic [2:0] cmd_write_lp = 3'b000;
  localparam logic [2:0] cmd_read_lp  = 3'b001;
  // Clears the in-burst offset so every burst starts on an aligned word.
  localparam logic [mem_els_lg_p-1:0] base_mask_lp = ~mem_els_lg_p'(ui_burst_len_p - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ} state_e;

  // Upper address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^app_addr_i;

  // ---------------- command queue ----------------
  logic [cmd_entry_w_lp-1:0] cmd_mem_q [cmd_fifo_depth_p];
  logic [cmd_ptr_w_lp-1:0]   cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic [cmd_cnt_w_lp-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic                      cmd_enq, cmd_deq, cmd_empty, cmd_full;
  logic [cmd_entry_w_lp-1:0] cmd_head;
  logic [2:0]                head_op;
  logic [mem_els_lg_p-1:0]   head_addr, addr_base;

  assign cmd_full  = (cmd_cnt_q == cmd_cnt_w_lp'(cmd_fifo_depth_p));
  assign cmd_empty = (cmd_cnt_q == '0);
  assign app_rdy_o = ~reset_i & ~stall_i & ~cmd_full;
  assign cmd_enq   = app_en_i & app_rdy_o;
  assign addr_base = app_addr_i[mem_els_lg_p-1:0] & base_mask_lp;
  assign cmd_head  = cmd_mem_q[cmd_rptr_q];
  assign head_op   = cmd_head[cmd_entry_w_lp-1 -: 3];
  assign head_addr = cmd_head[mem_els_lg_p-1:0];

  // ---------------- write-data queue ----------------
  logic [wdf_entry_w_lp-1:0]  wdf_mem_q [wdf_fifo_depth_p];
  logic [wdf_ptr_w_lp-1:0]    wdf_wptr_q, wdf_wptr_d, wdf_rptr_q, wdf_rptr_d;
  logic [wdf_cnt_w_lp-1:0]    wdf_cnt_q, wdf_cnt_d;
  logic                       wdf_enq, wdf_deq, wdf_empty, wdf_full;
  logic [wdf_entry_w_lp-1:0]  wdf_head;
  logic [ui_data_width_p-1:0] wdf_head_data;
  logic [mask_w_lp-1:0]       wdf_head_mask;
  logic                       wdf_head_end;

  assign wdf_full      = (wdf_cnt_q == wdf_cnt_w_lp'(wdf_fifo_depth_p));
  assign wdf_empty     = (wdf_cnt_q == '0);
  assign app_wdf_rdy_o = ~reset_i & ~stall_i & ~wdf_full;
  assign wdf_enq       = app_wdf_wren_i & app_wdf_rdy_o;
  assign wdf_head      = wdf_mem_q[wdf_rptr_q];
  assign {wdf_head_data, wdf_head_mask, wdf_head_end} = wdf_head;

  always_comb begin
    cmd_wptr_d = cmd_wptr_q;
    cmd_rptr_d = cmd_rptr_q;
    cmd_cnt_d  = cmd_cnt_q;
    wdf_wptr_d = wdf_wptr_q;
    wdf_rptr_d = wdf_rptr_q;
    wdf_cnt_d  = wdf_cnt_q;
    if (cmd_enq)
      cmd_wptr_d = (cmd_wptr_q == cmd_ptr_w_lp'(cmd_fifo_depth_p - 1)) ? '0 : cmd_wptr_q + cmd_ptr_w_lp'(1);
    if (cmd_deq)
      cmd_rptr_d = (cmd_rptr_q == cmd_ptr_w_lp'(cmd_fifo_depth_p - 1)) ? '0 : cmd_rptr_q + cmd_ptr_w_lp'(1);
    if (cmd_enq & ~cmd_deq)      cmd_cnt_d = cmd_cnt_q + cmd_cnt_w_lp'(1);
    else if (~cmd_enq & cmd_deq) cmd_cnt_d = cmd_cnt_q - cmd_cnt_w_lp'(1);
    if (wdf_enq)
      wdf_wptr_d = (wdf_wptr_q == wdf_ptr_w_lp'(wdf_fifo_depth_p - 1)) ? '0 : wdf_wptr_q + wdf_ptr_w_lp'(1);
    if (wdf_deq)
      wdf_rptr_d = (wdf_rptr_q == wdf_ptr_w_lp'(wdf_fifo_depth_p - 1)) ? '0 : wdf_rptr_q + wdf_ptr_w_lp'(1);
    if (wdf_enq & ~wdf_deq)      wdf_cnt_d = wdf_cnt_q + wdf_cnt_w_lp'(1);
    else if (~wdf_enq & wdf_deq) wdf_cnt_d = wdf_cnt_q - wdf_cnt_w_lp'(1);
  end

  // ---------------- burst engine ----------------
  state_e                     state_q, state_d;
  logic [beat_w_lp-1:0]       beat_q, beat_d;
  logic [lat_w_lp-1:0]        lat_q, lat_d;
  logic [mem_els_lg_p-1:0]    base_q, base_d;
  logic                       error_q, error_d;
  logic                       rd_valid_q, rd_valid_d, rd_end_q, rd_end_d;
  logic [ui_data_width_p-1:0] rd_data_q, rd_data_d;
  logic [ui_data_width_p-1:0] mem_q [mem_els_lp];
  logic                       mem_we, last_beat;
  logic [mem_els_lg_p-1:0]    beat_addr;

  assign last_beat = (beat_q == beat_w_lp'(ui_burst_len_p - 1));
  assign beat_addr = base_q | mem_els_lg_p'(beat_q);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    base_d     = base_q;
    error_d    = error_q;
    rd_valid_d = 1'b0;
    rd_end_d   = 1'b0;
    rd_data_d  = rd_data_q;
    cmd_deq    = 1'b0;
    wdf_deq    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cmd_empty) begin
          if (head_op == cmd_write_lp) begin
            // Start only once the whole burst is queued so WRITE never starves.
            if (wdf_cnt_q >= wdf_cnt_w_lp'(ui_burst_len_p)) begin
              cmd_deq = 1'b1;
              base_d  = head_addr;
              beat_d  = '0;
              state_d = WRITE;
            end
          end else if (head_op == cmd_read_lp) begin
            cmd_deq = 1'b1;
            base_d  = head_addr;
            beat_d  = '0;
            lat_d   = '0;
            state_d = (read_latency_p == 0) ? READ : READ_WAIT;
          end else begin
            cmd_deq = 1'b1;
          end
        end
      end
      WRITE: begin
        wdf_deq = 1'b1;
        mem_we  = 1'b1;
        if (wdf_head_end != last_beat) error_d = 1'b1;
        if (last_beat) state_d = IDLE;
        else           beat_d  = beat_q + beat_w_lp'(1);
      end
      READ_WAIT: begin
        if (lat_q == lat_w_lp'(lat_last_lp)) state_d = READ;
        else                                  lat_d   = lat_q + lat_w_lp'(1);
      end
      READ: begin
        rd_valid_d = 1'b1;
        rd_end_d   = last_beat;
        rd_data_d  = mem_q[beat_addr];
        if (last_beat) state_d = IDLE;
        else           beat_d  = beat_q + beat_w_lp'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      cmd_cnt_q  <= '0;
      wdf_wptr_q <= '0;
      wdf_rptr_q <= '0;
      wdf_cnt_q  <= '0;
      state_q    <= IDLE;
      beat_q     <= '0;
      lat_q      <= '0;
      base_q     <= '0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_end_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      cmd_wptr_q <= cmd_wptr_d;
      cmd_rptr_q <= cmd_rptr_d;
      cmd_cnt_q  <= cmd_cnt_d;
      wdf_wptr_q <= wdf_wptr_d;
      wdf_rptr_q <= wdf_rptr_d;
      wdf_cnt_q  <= wdf_cnt_d;
      state_q    <= state_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      base_q     <= base_d;
      error_q    <= error_d;
      rd_valid_q <= rd_valid_d;
      rd_end_q   <= rd_end_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Queue storage and the word memory carry no reset; validity is tracked
  // by the counters, and memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (cmd_enq) cmd_mem_q[cmd_wptr_q] <= {app_cmd_i, addr_base};
    if (wdf_enq) wdf_mem_q[wdf_wptr_q] <= {app_wdf_data_i, app_wdf_mask_i, app_wdf_end_i};
    if (mem_we) begin
      for (int b = 0; b < mask_w_lp; b++) begin
        if (!wdf_head_mask[b]) mem_q[beat_addr][b*8 +: 8] <= wdf_head_data[b*8 +: 8];
      end
    end
  end

  assign app_rd_data_valid_o = rd_valid_q;
  assign app_rd_data_o       = rd_data_q;
  assign app_rd_data_end_o   = rd_end_q;
  assign error_o             = error_q;
  assign busy_o              = (state_q != IDLE) | ~cmd_empty | ~wdf_empty;

endmodule

// File: tb/tb_bsg_dmc_ui_responder.sv
// Self-checking bench for bsg_dmc_ui_responder (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_bsg_dmc_ui_responder;

  localparam int W = 32;
  localparam logic [2:0] OP_WR = 3'b000;
  localparam logic [2:0] OP_RD = 3'b001;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_i;
  logic [27:0]   app_addr_i;
  logic [2:0]    app_cmd_i;
  logic          app_en_i;
  logic          app_rdy_o;
  logic          app_wdf_wren_i;
  logic [W-1:0]  app_wdf_data_i;
  logic [W/8-1:0] app_wdf_mask_i;
  logic          app_wdf_end_i;
  logic          app_wdf_rdy_o;
  logic          app_rd_data_valid_o;
  logic [W-1:0]  app_rd_data_o;
  logic          app_rd_data_end_o;
  logic          stall_i;
  logic          error_o;
  logic          busy_o;

  always #5 clk = ~clk;

  bsg_dmc_ui_responder dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .app_addr_i          (app_addr_i),
    .app_cmd_i           (app_cmd_i),
    .app_en_i            (app_en_i),
    .app_rdy_o           (app_rdy_o),
    .app_wdf_wren_i      (app_wdf_wren_i),
    .app_wdf_data_i      (app_wdf_data_i),
    .app_wdf_mask_i      (app_wdf_mask_i),
    .app_wdf_end_i       (app_wdf_end_i),
    .app_wdf_rdy_o       (app_wdf_rdy_o),
    .app_rd_data_valid_o (app_rd_data_valid_o),
    .app_rd_data_o       (app_rd_data_o),
    .app_rd_data_end_o   (app_rd_data_end_o),
    .stall_i             (stall_i),
    .error_o             (error_o),
    .busy_o              (busy_o)
  );

  // ---------------- checking ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_end_q[$];
  logic [W-1:0] model_mem [64];
  int           beats_seen = 0;
  logic [W-1:0] mon_exp_data;
  logic         mon_exp_end;

  always @(negedge clk) begin
    if (app_rd_data_valid_o === 1'b1) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 1, 0);
      end else begin
        mon_exp_data = exp_q.pop_front();
        mon_exp_end  = exp_end_q.pop_front();
        check_eq("rd_data", app_rd_data_o, mon_exp_data);
        check_eq("rd_end", app_rd_data_end_o, mon_exp_end);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [2:0] op, input logic [27:0] addr);
    int n = 0;
    while (app_rdy_o !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (app_rdy_o !== 1'b1) check_eq("cmd_rdy_timeout", app_rdy_o, 1);
    app_cmd_i  = op;
    app_addr_i = addr;
    app_en_i   = 1'b1;
    @(negedge clk);
    app_en_i   = 1'b0;
  endtask

  task automatic send_wdf(input logic [127:0] d, input logic [15:0] m, input logic [3:0] ends);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      app_wdf_wren_i = 1'b0;
      while (app_wdf_rdy_o !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (app_wdf_rdy_o !== 1'b1) check_eq("wdf_rdy_timeout", app_wdf_rdy_o, 1);
      app_wdf_wren_i = 1'b1;
      app_wdf_data_i = d[k*32 +: 32];
      app_wdf_mask_i = m[k*4 +: 4];
      app_wdf_end_i  = ends[k];
      @(negedge clk);
    end
    app_wdf_wren_i = 1'b0;
    app_wdf_end_i  = 1'b0;
  endtask

  task automatic model_write(input logic [27:0] addr, input logic [127:0] d, input logic [15:0] m);
    logic [5:0] base;
    base = addr[5:0] & 6'h3C;
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++)
        if (!m[k*4 + b]) model_mem[base + 6'(k)][b*8 +: 8] = d[k*32 + b*8 +: 8];
  endtask

  task automatic write_burst(input logic [27:0] addr, input logic [127:0] d,
                             input logic [15:0] m, input logic [3:0] ends);
    model_write(addr, d, m);
    send_cmd(OP_WR, addr);
    send_wdf(d, m, ends);
  endtask

  task automatic push_read(input logic [27:0] addr);
    logic [5:0] base;
    base = addr[5:0] & 6'h3C;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(model_mem[base + 6'(k)]);
      exp_end_q.push_back(k == 3);
    end
  endtask

  task automatic read_burst(input logic [27:0] addr);
    push_read(addr);
    send_cmd(OP_RD, addr);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, busy_o, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int beats0;
    int n;
    logic seen, busy_at_rise, all_busy;

    reset_i        = 1'b1;
    app_addr_i     = '0;
    app_cmd_i      = '0;
    app_en_i       = 1'b0;
    app_wdf_wren_i = 1'b0;
    app_wdf_data_i = '0;
    app_wdf_mask_i = '0;
    app_wdf_end_i  = 1'b0;
    stall_i        = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_rdy", app_rdy_o, 0);
    check_eq("rst_wdf_rdy", app_wdf_rdy_o, 0);
    check_eq("rst_valid", app_rd_data_valid_o, 0);
    check_eq("rst_end", app_rd_data_end_o, 0);
    check_eq("rst_data", app_rd_data_o, 0);
    check_eq("rst_error", error_o, 0);
    check_eq("rst_busy", busy_o, 0);
    reset_i = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rdy", app_rdy_o, 1);

    // Write then read at 0x10, with read latency check
    write_burst(28'h10, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'h0000, 4'b1000);
    wait_idle("wr1_idle");
    read_burst(28'h10);
    repeat (3) begin
      @(negedge clk);
      check_eq("lat_quiet", app_rd_data_valid_o, 0);
    end
    @(negedge clk);
    check_eq("lat_first_beat", app_rd_data_valid_o, 1);
    wait_drain("wr1_drain");
    check_eq("wr1_error", error_o, 0);

    // Masked write at 0x20
    write_burst(28'h20, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 16'h0000, 4'b1000);
    write_burst(28'h20, {32'h0, 32'h0, 32'h0, 32'h12345678}, 16'hFFF5, 4'b1000);
    wait_idle("mask_idle");
    exp_q.push_back(32'h12AA56AA); exp_end_q.push_back(1'b0);
    exp_q.push_back(32'hBBBBBBBB); exp_end_q.push_back(1'b0);
    exp_q.push_back(32'hCCCCCCCC); exp_end_q.push_back(1'b0);
    exp_q.push_back(32'hDDDDDDDD); exp_end_q.push_back(1'b1);
    send_cmd(OP_RD, 28'h20);
    wait_drain("mask_drain");

    // Data before command at 0x00 (upper address bits set, must be ignored)
    send_wdf({32'hA0A0A0A3, 32'hA0A0A0A2, 32'hA0A0A0A1, 32'hA0A0A0A0}, 16'h0000, 4'b1000);
    all_busy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy_o !== 1'b1) all_busy = 1'b0;
    end
    check_eq("dbc_busy", all_busy, 1);
    check_eq("dbc_no_beats", app_rd_data_valid_o, 0);
    model_write(28'h00, {32'hA0A0A0A3, 32'hA0A0A0A2, 32'hA0A0A0A1, 32'hA0A0A0A0}, 16'h0000);
    send_cmd(OP_WR, 28'hABC_DE00 | 28'h0000002);
    wait_idle("dbc_idle");
    read_burst(28'h00);
    wait_drain("dbc_drain");

    // Backpressure: queue fills while a read burst is active
    write_burst(28'h30, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 4'b1000);
    wait_idle("bp_prep_idle");
    beats0 = beats_seen;
    read_burst(28'h10);
    read_burst(28'h20);
    read_burst(28'h30);
    read_burst(28'h00);
    read_burst(28'h10);
    check_eq("full_rdy_low", app_rdy_o, 0);
    read_burst(28'h20);
    wait_drain("bp_drain");
    check_eq("bp_beat_count", beats_seen - beats0, 24);
    wait_idle("bp_idle");

    // Stall forces both readies low in the same cycle; nothing is accepted
    check_eq("pre_stall_rdy", app_rdy_o, 1);
    check_eq("pre_stall_wdf_rdy", app_wdf_rdy_o, 1);
    stall_i   = 1'b1;
    app_cmd_i = OP_RD;
    app_en_i  = 1'b1;
    #1;
    check_eq("stall_rdy", app_rdy_o, 0);
    check_eq("stall_wdf_rdy", app_wdf_rdy_o, 0);
    repeat (2) @(negedge clk);
    app_en_i = 1'b0;
    stall_i  = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("stall_no_accept", busy_o, 0);

    // Protocol error: end on the second beat
    check_eq("pre_err", error_o, 0);
    write_burst(28'h08, {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A}, 16'h0000, 4'b0010);
    seen = 1'b0;
    busy_at_rise = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      if (error_o === 1'b1) begin
        seen = 1'b1;
        busy_at_rise = busy_o;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("err_rise", seen, 1);
    check_eq("err_during_write", busy_at_rise, 1);
    wait_idle("err_idle");
    read_burst(28'h08);
    wait_drain("err_drain");
    check_eq("err_sticky", error_o, 1);
    reset_i = 1'b1;
    @(negedge clk);
    check_eq("err_cleared", error_o, 0);
    reset_i = 1'b0;
    @(negedge clk);

    // Reset during the second beat of a read burst
    read_burst(28'h10);
    n = 0;
    while (app_rd_data_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_first_beat", app_rd_data_valid_o, 1);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check_eq("mid_valid", app_rd_data_valid_o, 0);
    check_eq("mid_rdy", app_rdy_o, 0);
    check_eq("mid_busy", busy_o, 0);
    reset_i = 1'b0;
    exp_q.delete();
    exp_end_q.delete();
    beats0 = beats_seen;
    repeat (20) @(negedge clk);
    check_eq("mid_no_stale", beats_seen - beats0, 0);

    // Memory survives reset
    read_burst(28'h10);
    wait_drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
